// File: rtl/sap_cpu_core.sv
// Multi-cycle accumulator CPU with a loadable internal RAM, an explicit fetch/execute
// sequencer, carry/zero flags, conditional jumps and run/halt control.
module sap_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              carry,
    output logic              zero,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_F0   = 3'd1;
    localparam logic [2:0] ST_F1   = 3'd2;
    localparam logic [2:0] ST_E1   = 3'd3;
    localparam logic [2:0] ST_E2   = 3'd4;
    localparam logic [2:0] ST_E3   = 3'd5;
    localparam logic [2:0] ST_HALT = 3'd6;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_r;
    logic [2:0]        next_state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] mar_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              halted_r;
    logic              carry_r;
    logic              zero_r;
    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    logic [3:0]        opcode_s;
    logic [ADDR_W-1:0] operand_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W:0]   sum_s;
    logic [DATA_W-1:0] diff_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    assign opcode_s  = ir_r[DATA_W-1 -: 4];
    assign operand_s = ir_r[ADDR_W-1:0];
    assign rd_data_s = mem_r[mar_r];
    assign sum_s     = {1'b0, a_r} + {1'b0, b_r};
    assign diff_s    = a_r - b_r;

    // Bits between opcode and operand carry no meaning in the encoding.
    generate
        if (DATA_W > ADDR_W + 4) begin : g_ir_pad
            logic unused_ir_s;
            assign unused_ir_s = ^ir_r[DATA_W-5:ADDR_W];
        end
    endgenerate

    // Sequencer next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run) next_state_s = ST_F0;
                else     next_state_s = ST_IDLE;
            end
            ST_F0: begin
                if (run) next_state_s = ST_F1;
                else     next_state_s = ST_IDLE;
            end
            ST_F1: next_state_s = ST_E1;
            ST_E1: begin
                case (opcode_s)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: next_state_s = ST_E2;
                    OP_HLT:                         next_state_s = ST_HALT;
                    default:                        next_state_s = ST_F0;
                endcase
            end
            ST_E2: begin
                case (opcode_s)
                    OP_ADD, OP_SUB: next_state_s = ST_E3;
                    default:        next_state_s = ST_F0;
                endcase
            end
            ST_E3:   next_state_s = ST_F0;
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // RAM write port arbitration: core STA in E2, external load only while stopped.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = prog_addr;
        mem_wdata_s = prog_wdata;
        if ((state_r == ST_E2) && (opcode_s == OP_STA)) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = mar_r;
            mem_wdata_s = a_r;
        end else if (prog_we && ((state_r == ST_IDLE) || (state_r == ST_HALT))) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = prog_addr;
            mem_wdata_s = prog_wdata;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Program/data RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) mem_r[mem_waddr_s] <= mem_wdata_s;
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= next_state_s;
    end

    // Datapath registers, flags and output strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r        <= {ADDR_W{1'b0}};
            mar_r       <= {ADDR_W{1'b0}};
            a_r         <= {DATA_W{1'b0}};
            b_r         <= {DATA_W{1'b0}};
            ir_r        <= {DATA_W{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            halted_r    <= 1'b0;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            halted_r    <= (next_state_s == ST_HALT);
            case (state_r)
                ST_F0: begin
                    if (run) mar_r <= pc_r;
                end
                ST_F1: begin
                    ir_r <= rd_data_s;
                    pc_r <= pc_r + PC_INC;
                end
                ST_E1: begin
                    case (opcode_s)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_r <= operand_s;
                        OP_LDI: a_r  <= {{(DATA_W-ADDR_W){1'b0}}, operand_s};
                        OP_JMP: pc_r <= operand_s;
                        OP_JC: begin
                            if (carry_r) pc_r <= operand_s;
                        end
                        OP_JZ: begin
                            if (zero_r) pc_r <= operand_s;
                        end
                        OP_OUT: begin
                            out_data_r  <= a_r;
                            out_valid_r <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_E2: begin
                    case (opcode_s)
                        OP_LDA:         a_r <= rd_data_s;
                        OP_ADD, OP_SUB: b_r <= rd_data_s;
                        default: ;
                    endcase
                end
                ST_E3: begin
                    // SUB carry means "no borrow", i.e. A >= B unsigned.
                    if (opcode_s == OP_SUB) begin
                        a_r     <= diff_s;
                        carry_r <= (a_r >= b_r);
                        zero_r  <= (diff_s == {DATA_W{1'b0}});
                    end else begin
                        a_r     <= sum_s[DATA_W-1:0];
                        carry_r <= sum_s[DATA_W];
                        zero_r  <= (sum_s[DATA_W-1:0] == {DATA_W{1'b0}});
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign halted    = halted_r;
    assign carry     = carry_r;
    assign zero      = zero_r;
    assign pc        = pc_r;

endmodule

// File: tb/tb_sap_cpu_core.sv
// Directed bench for sap_cpu_core: an 8/4 instance for most programs and a 12/6
// instance repeating the basic add program.
module tb_sap_cpu_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run, prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_wdata;
    logic [7:0]  out_data;
    logic        out_valid, halted, carry, zero;
    logic [3:0]  pc;

    logic        run2, prog_we2;
    logic [5:0]  prog_addr2;
    logic [11:0] prog_wdata2;
    logic [11:0] out_data2;
    logic        out_valid2, halted2, carry2, zero2;
    logic [5:0]  pc2;

    int tests_run = 0;
    int tests_failed = 0;
    int pulse_cnt = 0;
    int pulse_cnt2 = 0;
    logic [7:0] out_hist [64];
    logic [7:0] img [16];
    int cyc;
    int base;

    sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .out_data(out_data), .out_valid(out_valid), .halted(halted),
        .carry(carry), .zero(zero), .pc(pc)
    );

    sap_cpu_core #(.DATA_W(12), .ADDR_W(6)) dut2 (
        .clk(clk), .rst(rst), .run(run2), .prog_we(prog_we2),
        .prog_addr(prog_addr2), .prog_wdata(prog_wdata2),
        .out_data(out_data2), .out_valid(out_valid2), .halted(halted2),
        .carry(carry2), .zero(zero2), .pc(pc2)
    );

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (pulse_cnt < 64) out_hist[pulse_cnt] = out_data;
            pulse_cnt = pulse_cnt + 1;
        end
        if (out_valid2 === 1'b1) pulse_cnt2 = pulse_cnt2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic write_word2(input logic [5:0] a, input logic [11:0] d);
        @(negedge clk);
        prog_we2 = 1'b1; prog_addr2 = a; prog_wdata2 = d;
        @(negedge clk);
        prog_we2 = 1'b0;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
    endtask

    task automatic load_img();
        for (int i = 0; i < 16; i++) write_word(i[3:0], img[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; run2 = 1'b0; prog_we = 1'b0; prog_we2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts the core from IDLE; cycles counts edges from the first F0 until halted.
    task automatic run_to_halt(input bit we_noise, output int cycles);
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        #1;
        if (we_noise) begin
            prog_we = 1'b1; prog_addr = 4'd10; prog_wdata = 8'h77;
        end
        cycles = 0;
        while (cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 6) prog_we = 1'b0;
            if (halted === 1'b1) break;
        end
        prog_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_wdata = 8'd0;
        run2 = 1'b0; prog_we2 = 1'b0; prog_addr2 = 6'd0; prog_wdata2 = 12'd0;
        #12;
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_flags", {30'd0, carry, zero}, 32'd0);
        check("rst_pc", {28'd0, pc}, 32'd0);
        check("rst_pc2", {26'd0, pc2}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // LDA 14; ADD 15; OUT; HLT with 28 + 14
        clear_img();
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
        img[14] = 8'd28; img[15] = 8'd14;
        load_img();
        base = pulse_cnt;
        run_to_halt(1'b0, cyc);
        check("t1_cycles", cyc, 32'd15);
        check("t1_out", {24'd0, out_data}, 32'd42);
        check("t1_pulses", pulse_cnt - base, 32'd1);
        check("t1_halted", {31'd0, halted}, 32'd1);
        check("t1_carry", {31'd0, carry}, 32'd0);
        check("t1_zero", {31'd0, zero}, 32'd0);
        check("t1_pc", {28'd0, pc}, 32'd4);
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t1_halt_sticky", {31'd0, halted}, 32'd1);

        // LDI/STA/LDA/SUB to zero, JZ taken, then read back the stored word
        do_reset();
        check("t2_rst_out", {24'd0, out_data}, 32'd0);
        check("t2_rst_halted", {31'd0, halted}, 32'd0);
        clear_img();
        img[0] = 8'h57; img[1] = 8'h49; img[2] = 8'h19; img[3] = 8'h39;
        img[4] = 8'h86; img[5] = 8'hF0; img[6] = 8'hE0; img[7] = 8'h19;
        img[8] = 8'hE0; img[10] = 8'hF0;
        load_img();
        base = pulse_cnt;
        run_to_halt(1'b0, cyc);
        check("t2_cycles", cyc, 32'd35);
        check("t2_pulses", pulse_cnt - base, 32'd2);
        check("t2_first_out", {24'd0, out_hist[base]}, 32'd0);
        check("t2_sta_readback", {24'd0, out_data}, 32'd7);
        check("t2_carry", {31'd0, carry}, 32'd1);
        check("t2_zero", {31'd0, zero}, 32'd1);
        check("t2_pc", {28'd0, pc}, 32'd11);

        // 0xFF + 0x01 wraps with C=1,Z=1; JC taken; 0+1 clears Z so JZ falls through
        do_reset();
        clear_img();
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h74; img[3] = 8'hF0;
        img[4] = 8'hE0; img[5] = 8'h2D; img[6] = 8'h89; img[7] = 8'hE0;
        img[8] = 8'hF0; img[9] = 8'h55; img[10] = 8'hE0; img[11] = 8'hF0;
        img[13] = 8'h01; img[14] = 8'hFF; img[15] = 8'h01;
        load_img();
        base = pulse_cnt;
        run_to_halt(1'b0, cyc);
        check("t3_cycles", cyc, 32'd29);
        check("t3_pulses", pulse_cnt - base, 32'd2);
        check("t3_wrap_sum", {24'd0, out_hist[base]}, 32'd0);
        check("t3_jz_fall", {24'd0, out_data}, 32'd1);
        check("t3_flags", {30'd0, carry, zero}, 32'd0);
        check("t3_pc", {28'd0, pc}, 32'd9);

        // PC wraps 15 -> 0 and fetch continues at address 0 (JC now taken)
        do_reset();
        clear_img();
        img[0] = 8'h74; img[1] = 8'h13; img[2] = 8'h6E; img[3] = 8'hFF;
        img[4] = 8'hE0; img[5] = 8'hF0; img[14] = 8'h23; img[15] = 8'h00;
        load_img();
        base = pulse_cnt;
        run_to_halt(1'b0, cyc);
        check("t4_cycles", cyc, 32'd27);
        check("t4_out", {24'd0, out_data}, 32'hFE);
        check("t4_pulses", pulse_cnt - base, 32'd1);
        check("t4_flags", {30'd0, carry, zero}, 32'd2);
        check("t4_pc", {28'd0, pc}, 32'd6);

        // rst during E2 of STA must not commit the write
        do_reset();
        clear_img();
        img[0] = 8'h55; img[1] = 8'h4A; img[2] = 8'hF0; img[10] = 8'h33;
        load_img();
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #2;
        check("t5_pc_in_e2", {28'd0, pc}, 32'd2);
        rst = 1'b1;
        #1;
        check("t5_rst_pc", {28'd0, pc}, 32'd0);
        check("t5_rst_outs", {22'd0, out_data, out_valid, halted}, 32'd0);
        check("t5_rst_flags", {30'd0, carry, zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0; run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_idle_pc", {28'd0, pc}, 32'd0);
        write_word(4'd0, 8'h1A);
        write_word(4'd1, 8'hE0);
        write_word(4'd2, 8'hF0);
        base = pulse_cnt;
        run_to_halt(1'b1, cyc);
        check("t5_cycles", cyc, 32'd10);
        check("t5_word_kept", {24'd0, out_data}, 32'h33);
        check("t5_pulses", pulse_cnt - base, 32'd1);

        // run dropped during ADD: ADD completes, core idles at PC=2, then resumes
        do_reset();
        clear_img();
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
        img[14] = 8'd28; img[15] = 8'd14;
        load_img();
        base = pulse_cnt;
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        run = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("t6_stop_halted", {31'd0, halted}, 32'd0);
        check("t6_stop_pc", {28'd0, pc}, 32'd2);
        check("t6_stop_pulses", pulse_cnt - base, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_pc_held", {28'd0, pc}, 32'd2);
        run_to_halt(1'b0, cyc);
        check("t6_resume_cycles", cyc, 32'd6);
        check("t6_out", {24'd0, out_data}, 32'd42);
        check("t6_pulses", pulse_cnt - base, 32'd1);
        check("t6_pc", {28'd0, pc}, 32'd4);

        // 12-bit data / 6-bit address instance: 2000 + 250
        write_word2(6'd0, 12'h10E);
        write_word2(6'd1, 12'h20F);
        write_word2(6'd2, 12'hE00);
        write_word2(6'd3, 12'hF00);
        write_word2(6'd14, 12'h7D0);
        write_word2(6'd15, 12'h0FA);
        base = pulse_cnt2;
        @(negedge clk);
        run2 = 1'b1;
        @(posedge clk);
        cyc = 0;
        while (cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (halted2 === 1'b1) break;
        end
        check("t7_cycles", cyc, 32'd15);
        check("t7_out", {20'd0, out_data2}, 32'h8CA);
        check("t7_pulses", pulse_cnt2 - base, 32'd1);
        check("t7_flags", {30'd0, carry2, zero2}, 32'd0);
        check("t7_pc", {26'd0, pc2}, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
